// File: rtl/turn_timer_pkg.sv
// Shared definitions for the per-move turn timer: FSM state encodings.
package turn_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } turn_timer_state_e;

endpackage : turn_timer_pkg

// File: rtl/turn_timer_down_counter.sv
// Loadable down-counting turn timer. Counts external enable ticks down from a
// loaded value and pulses expired for one cycle on reaching zero.
// Optional feature macro: TURN_TIMER_PAUSE_EN (pause input freezes the count
// while running). Without it, the pause input is accepted but has no effect.
module turn_timer_down_counter
    import turn_timer_pkg::*;
#(
    parameter int   START_VALUE = 9,
    parameter bit   USE_DEFAULT = 1'b1,
    localparam int  WIDTH       = $clog2(START_VALUE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic [WIDTH-1:0] load_value,
    input  logic             abort,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired
);

    localparam logic [WIDTH-1:0] START_VAL_W = WIDTH'(START_VALUE);
    localparam logic [WIDTH-1:0] ONE_W       = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_W      = WIDTH'(0);

    turn_timer_state_e state_r;
    turn_timer_state_e state_nxt_s;
    logic [WIDTH-1:0]  count_r;
    logic [WIDTH-1:0]  count_nxt_s;
    logic [WIDTH-1:0]  eff_load_s;
    logic              busy_r;
    logic              expired_r;
    logic              pause_s;

`ifdef TURN_TIMER_PAUSE_EN
    assign pause_s = pause;
`else
    // Pause is part of the port list in every build but is only honoured
    // when the feature is compiled in.
    logic unused_pause_s;
    assign unused_pause_s = pause;
    assign pause_s        = 1'b0;
`endif

    // Effective reload value: a zero load selects the default when enabled.
    always_comb begin
        eff_load_s = load_value;
        if ((load_value == ZERO_W) && (USE_DEFAULT == 1'b1)) begin
            eff_load_s = START_VAL_W;
        end else begin
            eff_load_s = load_value;
        end
    end

    // Next state and count; priority abort > start > pause > tick.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = ZERO_W;
                end else if (start) begin
                    state_nxt_s = (eff_load_s == ZERO_W) ? ST_DONE : ST_RUN;
                    count_nxt_s = eff_load_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = ZERO_W;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = ZERO_W;
                end else if (start) begin
                    // Restart: reload, any simultaneous tick is discarded.
                    state_nxt_s = (eff_load_s == ZERO_W) ? ST_DONE : ST_RUN;
                    count_nxt_s = eff_load_s;
                end else if (pause_s) begin
                    state_nxt_s = ST_RUN;
                    count_nxt_s = count_r;
                end else if (tick) begin
                    if (count_r > ONE_W) begin
                        state_nxt_s = ST_RUN;
                        count_nxt_s = count_r - ONE_W;
                    end else begin
                        // Last tick (count 1), or a stray zero: never wrap.
                        state_nxt_s = ST_DONE;
                        count_nxt_s = ZERO_W;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                    count_nxt_s = count_r;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = ZERO_W;
                end else if (start) begin
                    state_nxt_s = (eff_load_s == ZERO_W) ? ST_DONE : ST_RUN;
                    count_nxt_s = eff_load_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = ZERO_W;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                count_nxt_s = ZERO_W;
            end
        endcase
    end

    // State, count and Moore outputs registered together from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            count_r   <= ZERO_W;
            busy_r    <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            count_r   <= count_nxt_s;
            busy_r    <= (state_nxt_s == ST_RUN);
            expired_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign count   = count_r;
    assign busy    = busy_r;
    assign expired = expired_r;

endmodule : turn_timer_down_counter

// File: tb/tb_turn_timer_down_counter.sv
// Directed self-checking bench for turn_timer_down_counter. A second instance
// with USE_DEFAULT=0 shares the stimulus and is checked for the zero-load case.
module tb_turn_timer_down_counter;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start;
    logic [3:0] load_value;
    logic       abort;
    logic       pause;
    logic [3:0] count;
    logic       busy;
    logic       expired;
    logic [3:0] count_nd;
    logic       busy_nd;
    logic       expired_nd;

    int checks_r   = 0;
    int failures_r = 0;

    turn_timer_down_counter #(.START_VALUE(9), .USE_DEFAULT(1'b1)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .load_value(load_value), .abort(abort), .pause(pause),
        .count(count), .busy(busy), .expired(expired)
    );

    turn_timer_down_counter #(.START_VALUE(9), .USE_DEFAULT(1'b0)) dut_nd (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .load_value(load_value), .abort(abort), .pause(pause),
        .count(count_nd), .busy(busy_nd), .expired(expired_nd)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (got !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at negedge, sample #1 after the following posedge.
    task automatic step(input logic s, input logic t, input logic a,
                        input logic p, input logic [3:0] lv);
        @(negedge clk);
        start      = s;
        tick       = t;
        abort      = a;
        pause      = p;
        load_value = lv;
        @(posedge clk);
        #1;
        start = 1'b0;
        tick  = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; abort = 1'b0;
        pause = 1'b0; load_value = 4'd0;
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_expired", 32'(expired), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Load 3, tick every 4 clocks down to expiry.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        check("t2_load_count", 32'(count), 32'd3);
        check("t2_load_busy", 32'(busy), 32'd1);
        check("t2_load_exp", 32'(expired), 32'd0);
        idle(3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("t2_tick1", 32'(count), 32'd2);
        idle(3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("t2_tick2", 32'(count), 32'd1);
        check("t2_tick2_exp", 32'(expired), 32'd0);
        idle(3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("t2_tick3_count", 32'(count), 32'd0);
        check("t2_tick3_exp", 32'(expired), 32'd1);
        check("t2_tick3_busy", 32'(busy), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("t2_exp_one_cycle", 32'(expired), 32'd0);
        check("t2_idle_count", 32'(count), 32'd0);

        // Async reset mid-run at count 5.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd7);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("t1_pre_count", 32'(count), 32'd5);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t1_count", 32'(count), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_expired", 32'(expired), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Zero load: default reload vs immediate expiry.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check("t3_def_count", 32'(count), 32'd9);
        check("t3_def_busy", 32'(busy), 32'd1);
        check("t3_nd_expired", 32'(expired_nd), 32'd1);
        check("t3_nd_busy", 32'(busy_nd), 32'd0);
        check("t3_nd_count", 32'(count_nd), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("t3_abort_count", 32'(count), 32'd0);
        check("t3_abort_busy", 32'(busy), 32'd0);
        check("t3_nd_exp_end", 32'(expired_nd), 32'd0);

        // Abort beats a simultaneous tick at count 2; no expiry afterwards.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        check("t4_count", 32'(count), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_exp", 32'(expired), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            check("t4_no_exp", 32'(expired), 32'd0);
            check("t4_idle_count", 32'(count), 32'd0);
        end

        // Restart at count 1 wins over the tick that would have expired it.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd4);
        check("t5_count", 32'(count), 32'd4);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_exp", 32'(expired), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("t5_exp_after", 32'(expired), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Start during the DONE cycle relaunches the timer.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("done_exp", 32'(expired), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        check("done_restart_count", 32'(count), 32'd2);
        check("done_restart_busy", 32'(busy), 32'd1);
        check("done_restart_exp", 32'(expired), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Pause over three ticks at count 6, then a normal tick.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd6);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
            idle(1);
        end
`ifdef TURN_TIMER_PAUSE_EN
        check("t6_paused_count", 32'(count), 32'd6);
`else
        check("t6_paused_count", 32'(count), 32'd3);
`endif
        check("t6_paused_busy", 32'(busy), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
`ifdef TURN_TIMER_PAUSE_EN
        check("t6_resume_count", 32'(count), 32'd5);
`else
        check("t6_resume_count", 32'(count), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule : tb_turn_timer_down_counter
